// File: rtl/duty_pkg.sv
// Shared types and defaults for the duty stepper: axis FSM states, button
// direction codes and the default duty limits.
package duty_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } axis_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10
    } dir_e;

    localparam int unsigned DUTY_INIT_DEF = 32;
    localparam int unsigned DUTY_MIN_DEF  = 4;
    localparam int unsigned DUTY_MAX_DEF  = 59;

    // Opposing presses cancel to DIR_NONE.
    function automatic dir_e decode_dir(input logic pos, input logic neg);
        dir_e d;
        d = DIR_NONE;
        if (pos && !neg) begin
            d = DIR_POS;
        end else if (neg && !pos) begin
            d = DIR_NEG;
        end
        return d;
    endfunction

endpackage

// File: rtl/duty_stepper_if.sv
// Button inputs and duty outputs of the duty stepper, grouped as one bundle.
// slave: the stepper itself; master: whatever drives the buttons.
interface duty_stepper_if #(
    parameter int unsigned WIDTH = 6
);
    logic             Bt_Up;
    logic             Bt_Down;
    logic             Bt_Left;
    logic             Bt_Right;
    logic [WIDTH-1:0] Duty_X;
    logic [WIDTH-1:0] Duty_Y;
    logic             Step_Pulse;

    modport master (
        output Bt_Up, Bt_Down, Bt_Left, Bt_Right,
        input  Duty_X, Duty_Y, Step_Pulse
    );

    modport slave (
        input  Bt_Up, Bt_Down, Bt_Left, Bt_Right,
        output Duty_X, Duty_Y, Step_Pulse
    );
endinterface

// File: rtl/axis_stepper.sv
// One axis of the duty stepper: direction decode, IDLE/HOLD/REPEAT FSM with
// hold/repeat timer, and a clamped duty register.
// Optional macro DUTY_STEPPER_ACCEL_EN: after 8 consecutive repeats the repeat
// interval shortens to REPEAT_PERIOD/4.
module axis_stepper
    import duty_pkg::*;
#(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned DUTY_INIT     = DUTY_INIT_DEF,
    parameter int unsigned DUTY_MIN      = DUTY_MIN_DEF,
    parameter int unsigned DUTY_MAX      = DUTY_MAX_DEF,
    parameter int unsigned STEP          = 1,
    parameter int unsigned HOLD_DELAY    = 12000000,
    parameter int unsigned REPEAT_PERIOD = 2500000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pos_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] duty_o,
    output logic             change_o
);

    localparam int unsigned TMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef logic [TW-1:0] timer_t;

    localparam timer_t        HoldLoad = timer_t'(HOLD_DELAY - 1);
    localparam timer_t        RepLoad  = timer_t'(REPEAT_PERIOD - 1);
    localparam timer_t        TimerOne = timer_t'(1);
    localparam logic [WIDTH:0] StepExt = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] MinExt  = (WIDTH + 1)'(DUTY_MIN);
    localparam logic [WIDTH:0] MaxExt  = (WIDTH + 1)'(DUTY_MAX);

`ifdef DUTY_STEPPER_ACCEL_EN
    localparam int unsigned FAST_PERIOD = (REPEAT_PERIOD / 4 > 0) ? REPEAT_PERIOD / 4 : 1;
    localparam timer_t      FastLoad    = timer_t'(FAST_PERIOD - 1);
    localparam logic [3:0]  RptSat      = 4'd8;
`endif

    // Elaboration-time legality of the duty limits and timer periods.
    if (!(DUTY_MIN <= DUTY_INIT && DUTY_INIT <= DUTY_MAX && DUTY_MAX < (1 << WIDTH)
          && HOLD_DELAY >= 1 && REPEAT_PERIOD >= 1)) begin : g_param_check
        $error("axis_stepper: illegal duty limits or timer periods");
    end

    axis_state_e      state_q, state_d;
    dir_e             dir_q, dir_d;
    dir_e             dir;
    timer_t           timer_q, timer_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             change_q, change_d;
    logic             do_step;
    logic [WIDTH:0]   duty_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] duty_next;

`ifdef DUTY_STEPPER_ACCEL_EN
    logic [3:0] rpt_q, rpt_d;
`endif

    // FSM next state, timer reload/decrement and step request.
    always_comb begin : next_state
        dir     = decode_dir(pos_i, neg_i);
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        // Armed once no direction is seen after reset, so a button held
        // through reset never steps until it is re-pressed.
        armed_d = armed_q | (dir == DIR_NONE);
        do_step = 1'b0;
`ifdef DUTY_STEPPER_ACCEL_EN
        rpt_d   = rpt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (armed_q && dir != DIR_NONE) begin
                    do_step = 1'b1;
                    dir_d   = dir;
                    timer_d = HoldLoad;
                    state_d = StHold;
                end
            end
            StHold, StRepeat: begin
                if (dir == DIR_NONE) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (dir != dir_q) begin
                    // Reversal behaves like a fresh press in the new direction.
                    do_step = 1'b1;
                    dir_d   = dir;
                    timer_d = HoldLoad;
                    state_d = StHold;
                end else if (timer_q == '0) begin
                    do_step = 1'b1;
                    state_d = StRepeat;
`ifdef DUTY_STEPPER_ACCEL_EN
                    if (state_q == StRepeat) begin
                        rpt_d   = (rpt_q == RptSat) ? RptSat : rpt_q + 4'd1;
                        timer_d = (rpt_d == RptSat) ? FastLoad : RepLoad;
                    end else begin
                        timer_d = RepLoad;
                    end
`else
                    timer_d = RepLoad;
`endif
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
`ifdef DUTY_STEPPER_ACCEL_EN
        if (state_d != StRepeat) begin
            rpt_d = '0;
        end
`endif
    end

    // Saturating step at WIDTH+1 bits; change flag only when the value moves.
    always_comb begin : step_math
        duty_ext = {1'b0, duty_q};
        sum      = duty_ext + StepExt;
        if (dir_d == DIR_NEG) begin
            duty_next = (duty_ext < MinExt + StepExt) ? WIDTH'(MinExt)
                                                      : WIDTH'(duty_ext - StepExt);
        end else begin
            duty_next = (sum > MaxExt) ? WIDTH'(MaxExt) : WIDTH'(sum);
        end
        duty_d   = do_step ? duty_next : duty_q;
        change_d = (duty_d != duty_q);
    end

    // Axis state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            dir_q    <= DIR_NONE;
            timer_q  <= '0;
            armed_q  <= 1'b0;
            duty_q   <= WIDTH'(DUTY_INIT);
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
            armed_q  <= armed_d;
            duty_q   <= duty_d;
            change_q <= change_d;
        end
    end

`ifdef DUTY_STEPPER_ACCEL_EN
    // Consecutive repeat counter for the fast slew.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign duty_o   = duty_q;
    assign change_o = change_q;

endmodule

// File: rtl/duty_stepper.sv
// Two-axis duty stepper: buttons to saturating X/Y duty words for the PWM
// stage. Optional macro DUTY_STEPPER_ACCEL_EN enables repeat acceleration.
module duty_stepper
    import duty_pkg::*;
#(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned DUTY_INIT     = DUTY_INIT_DEF,
    parameter int unsigned DUTY_MIN      = DUTY_MIN_DEF,
    parameter int unsigned DUTY_MAX      = DUTY_MAX_DEF,
    parameter int unsigned STEP          = 1,
    parameter int unsigned HOLD_DELAY    = 12000000,
    parameter int unsigned REPEAT_PERIOD = 2500000
) (
    input  logic          sysclk,
    input  logic          Reset_Sw,
    duty_stepper_if.slave bus
);

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int;
    logic       change_x, change_y;

    // Reset release synchroniser; assertion stays asynchronous.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    // Two-stage reset release pipeline.
    always_ff @(posedge sysclk or posedge Reset_Sw) begin
        if (Reset_Sw) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int = rst_sync_q[1];

    axis_stepper #(
        .WIDTH         (WIDTH),
        .DUTY_INIT     (DUTY_INIT),
        .DUTY_MIN      (DUTY_MIN),
        .DUTY_MAX      (DUTY_MAX),
        .STEP          (STEP),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_axis_x (
        .clk_i    (sysclk),
        .rst_i    (rst_int),
        .pos_i    (bus.Bt_Right),
        .neg_i    (bus.Bt_Left),
        .duty_o   (bus.Duty_X),
        .change_o (change_x)
    );

    axis_stepper #(
        .WIDTH         (WIDTH),
        .DUTY_INIT     (DUTY_INIT),
        .DUTY_MIN      (DUTY_MIN),
        .DUTY_MAX      (DUTY_MAX),
        .STEP          (STEP),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_axis_y (
        .clk_i    (sysclk),
        .rst_i    (rst_int),
        .pos_i    (bus.Bt_Up),
        .neg_i    (bus.Bt_Down),
        .duty_o   (bus.Duty_Y),
        .change_o (change_y)
    );

    // Simultaneous X and Y steps yield a single pulse.
    assign bus.Step_Pulse = change_x | change_y;

endmodule

// File: tb/tb_duty_stepper.sv
// Directed bench for duty_stepper with a scoreboard of expected (X,Y) pairs,
// one entry per Step_Pulse.
module tb_duty_stepper;
    import duty_pkg::*;

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
    } exp_t;

    logic sysclk;
    logic Reset_Sw;
    int   n_checks;
    int   n_fail;
    int   n_pulses;
    int   pulses_before;
    exp_t exp_q[$];

    duty_stepper_if #(.WIDTH(6)) bus ();

    duty_stepper #(
        .HOLD_DELAY    (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .sysclk   (sysclk),
        .Reset_Sw (Reset_Sw),
        .bus      (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y);
        exp_t e;
        e.x = 6'(x);
        e.y = 6'(y);
        exp_q.push_back(e);
    endtask

    // One clock; sample just after the edge and score any step pulse.
    task automatic cyc();
        exp_t e;
        @(posedge sysclk);
        #1;
        if (bus.Step_Pulse === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(bus.Step_Pulse), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_x", 32'(bus.Duty_X), 32'(e.x));
                check("sb_y", 32'(bus.Duty_Y), 32'(e.y));
            end
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    // Steps taken after i cycles of a hold (HOLD_DELAY=10, REPEAT_PERIOD=4).
    function automatic int hold_steps(input int i);
        if (i < 1) return 0;
        if (i < 11) return 1;
        return 2 + (i - 11) / 4;
    endfunction

    initial begin
        int ex;
        n_checks = 0;
        n_fail   = 0;
        n_pulses = 0;
        Reset_Sw = 1'b0;
        bus.Bt_Up = 1'b0;
        bus.Bt_Down = 1'b0;
        bus.Bt_Left = 1'b0;
        bus.Bt_Right = 1'b0;

        // Reset asserted mid-cycle with Bt_Up already held.
        #3;
        Reset_Sw = 1'b1;
        bus.Bt_Up = 1'b1;
        #1;
        check("rst_x", 32'(bus.Duty_X), 32'd32);
        check("rst_y", 32'(bus.Duty_Y), 32'd32);
        check("rst_pulse", 32'(bus.Step_Pulse), 32'd0);
        cycles(3);
        Reset_Sw = 1'b0;
        cycles(8);
        check("held_through_reset_y", 32'(bus.Duty_Y), 32'd32);
        bus.Bt_Up = 1'b0;
        cyc();
        bus.Bt_Up = 1'b1;
        push(32, 33);
        cyc();
        check("repress_y", 32'(bus.Duty_Y), 32'd33);
        bus.Bt_Up = 1'b0;
        cyc();

        // Second reset back to centre.
        Reset_Sw = 1'b1;
        #1;
        check("rst2_y", 32'(bus.Duty_Y), 32'd32);
        cycles(2);
        Reset_Sw = 1'b0;
        cycles(3);

        // Short Bt_Right pulse: exactly one step.
        pulses_before = n_pulses;
        bus.Bt_Right = 1'b1;
        push(33, 32);
        cycles(3);
        bus.Bt_Right = 1'b0;
        cycles(2);
        check("right_x", 32'(bus.Duty_X), 32'd33);
        check("right_y", 32'(bus.Duty_Y), 32'd32);
        check("right_pulses", 32'(n_pulses - pulses_before), 32'd1);
        check("right_drain", 32'(exp_q.size()), 32'd0);

        // Bt_Up held 30 cycles: hold delay then auto-repeat.
        bus.Bt_Up = 1'b1;
        for (int v = 33; v <= 38; v++) push(33, v);
        for (int i = 1; i <= 30; i++) begin
            cyc();
            check("hold_y", 32'(bus.Duty_Y), 32'(32 + hold_steps(i)));
        end
        bus.Bt_Up = 1'b0;
        cyc();
        check("hold_drain", 32'(exp_q.size()), 32'd0);

        // Bt_Left held down to the lower bound, then stays there.
        bus.Bt_Left = 1'b1;
        for (int v = 32; v >= 4; v--) push(v, 38);
        for (int i = 1; i <= 130; i++) begin
            cyc();
            ex = 33 - hold_steps(i);
            if (ex < 4) ex = 4;
            check("left_x", 32'(bus.Duty_X), 32'(ex));
        end
        bus.Bt_Left = 1'b0;
        cyc();
        check("left_drain", 32'(exp_q.size()), 32'd0);

        // Both Y buttons from IDLE cancel.
        bus.Bt_Up = 1'b1;
        bus.Bt_Down = 1'b1;
        cycles(5);
        check("both_y", 32'(bus.Duty_Y), 32'd38);
        check("both_state", 32'(dut.u_axis_y.state_q), 32'(StIdle));
        bus.Bt_Up = 1'b0;
        bus.Bt_Down = 1'b0;
        cyc();

        // Bt_Up held, then Bt_Down added: back to IDLE, no step.
        bus.Bt_Up = 1'b1;
        push(4, 39);
        cyc();
        check("up_then_y", 32'(bus.Duty_Y), 32'd39);
        cycles(3);
        bus.Bt_Down = 1'b1;
        cyc();
        check("cancel_state", 32'(dut.u_axis_y.state_q), 32'(StIdle));
        cycles(12);
        check("cancel_y", 32'(bus.Duty_Y), 32'd39);
        check("cancel_drain", 32'(exp_q.size()), 32'd0);
        bus.Bt_Up = 1'b0;
        bus.Bt_Down = 1'b0;
        cyc();

        // Reversal mid-hold steps at once and restarts the hold delay.
        bus.Bt_Up = 1'b1;
        push(4, 40);
        cyc();
        check("rev_up_y", 32'(bus.Duty_Y), 32'd40);
        cycles(4);
        bus.Bt_Up = 1'b0;
        bus.Bt_Down = 1'b1;
        push(4, 39);
        cyc();
        check("rev_step_y", 32'(bus.Duty_Y), 32'd39);
        cycles(9);
        check("rev_wait_y", 32'(bus.Duty_Y), 32'd39);
        push(4, 38);
        cyc();
        check("rev_repeat_y", 32'(bus.Duty_Y), 32'd38);
        bus.Bt_Down = 1'b0;
        cyc();
        check("rev_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
